// File: rtl/jesd204b_pkg.sv
// jesd204b_pkg
// Shared constants and types for the JESD204B link-layer scrambler and
// descrambler (polynomial 1 + x^14 + x^15, 32-bit words, MSB earliest).
// Both ends take their reset history from JESD204B_SCR_SEED.
package jesd204b_pkg;

    localparam int          JESD204B_W        = 32;
    localparam int          JESD204B_HIST_W   = 15;
    localparam int          JESD204B_TAP_A    = 14;
    localparam int          JESD204B_TAP_B    = 15;
    localparam logic [14:0] JESD204B_SCR_SEED = 15'h7F80;

    typedef enum logic {
        LOCK_ST_UNLOCKED = 1'b0,
        LOCK_ST_LOCKED   = 1'b1
    } lock_state_e;

endpackage

// File: rtl/jesd204b_descr_comb.sv
// jesd204b_descr_comb
// Purely combinational descrambler core: D[i] = S[i] ^ S[i+14] ^ S[i+15]
// over the extended vector {hist, s_in}, where hist holds the previous
// accepted word's low 15 bits (S[32..46]).
// Ports:
//   s_in  in  32  scrambled word, bit 31 earliest
//   hist  in  15  previous word's s_in[14:0]
//   d     out 32  descrambled word
module jesd204b_descr_comb
    import jesd204b_pkg::*;
(
    input  logic [JESD204B_W-1:0]      s_in,
    input  logic [JESD204B_HIST_W-1:0] hist,
    output logic [JESD204B_W-1:0]      d
);

    logic [JESD204B_W+JESD204B_HIST_W-1:0] ext;

    assign ext = {hist, s_in};

    always_comb begin
        d = '0;
        for (int i = 0; i < JESD204B_W; i++)
            d[i] = ext[i] ^ ext[i+JESD204B_TAP_A] ^ ext[i+JESD204B_TAP_B];
    end

endmodule

// File: rtl/jesd204b_descrambler.sv
// jesd204b_descrambler
// Receive-side self-synchronous descrambler for one JESD204B lane.
// Accepted words (s_valid) always refresh the 15-bit history; a resync
// pulse drops exactly one accepted word, used only to reseed history.
// Optional feature macro: JESD204B_DESCR_BYPASS_EN adds a 'bypass' input
// that forwards s_in unchanged (timing and qualifiers unaffected).
// Ports:
//   clk       in   1   rising-edge clock
//   reset     in   1   asynchronous active-high reset
//   s_in      in   32  scrambled word, bit 31 earliest
//   s_valid   in   1   s_in qualifier
//   resync    in   1   history unknown; relock on next accepted word
//   bypass    in   1   (macro only) pass s_in straight through
//   d_out     out  32  descrambled word
//   d_valid   out  1   d_out qualifier
//   locked    out  1   history trustworthy
//   word_cnt  out  16  words emitted since last relock, saturating
module jesd204b_descrambler
    import jesd204b_pkg::*;
#(
    parameter logic [14:0] SEED = JESD204B_SCR_SEED
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] s_in,
    input  logic        s_valid,
    input  logic        resync,
`ifdef JESD204B_DESCR_BYPASS_EN
    input  logic        bypass,
`endif
    output logic [31:0] d_out,
    output logic        d_valid,
    output logic        locked,
    output logic [15:0] word_cnt
);

    lock_state_e state, state_nxt, state_eff;
    logic        emit;
    logic        relock;
    logic [14:0] hist;
    logic [31:0] d_comb;
    logic [31:0] d_sel;

    jesd204b_descr_comb u_comb (
        .s_in (s_in),
        .hist (hist),
        .d    (d_comb)
    );

`ifdef JESD204B_DESCR_BYPASS_EN
    assign d_sel = bypass ? s_in : d_comb;
`else
    assign d_sel = d_comb;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= LOCK_ST_LOCKED;
        else       state <= state_nxt;
    end

    // resync overrides the current state for this cycle, so a word arriving
    // together with resync is already treated as the relock word.
    always_comb begin
        state_eff = resync ? LOCK_ST_UNLOCKED : state;
        state_nxt = state_eff;
        emit      = 1'b0;
        relock    = 1'b0;
        if (s_valid) begin
            if (state_eff == LOCK_ST_LOCKED) begin
                emit = 1'b1;
            end else begin
                relock    = 1'b1;
                state_nxt = LOCK_ST_LOCKED;
            end
        end
    end

    assign locked = (state == LOCK_ST_LOCKED);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hist     <= SEED;
            d_out    <= '0;
            d_valid  <= 1'b0;
            word_cnt <= '0;
        end else begin
            d_valid <= emit;
            if (s_valid)
                hist <= s_in[14:0];
            if (emit) begin
                d_out <= d_sel;
                if (word_cnt != 16'hFFFF)
                    word_cnt <= word_cnt + 16'd1;
            end
            if (relock)
                word_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_jesd204b_descrambler.sv
module tb_jesd204b_descrambler;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] s_in;
    logic        s_valid;
    logic        resync;
`ifdef JESD204B_DESCR_BYPASS_EN
    logic        bypass;
`endif
    logic [31:0] d_out;
    logic        d_valid;
    logic        locked;
    logic [15:0] word_cnt;

    int n_cmp = 0;
    int n_err = 0;

    logic [14:0] tx_hist;
    logic [31:0] dat [1003];

    typedef struct {
        logic        rs;
        logic        sv;
        logic [31:0] si;
        logic        chk_d;
        logic [31:0] ed;
        logic        edv;
        logic        elk;
        logic [15:0] ecnt;
    } vec_t;

    vec_t tbl [13];

    jesd204b_descrambler dut (
        .clk      (clk),
        .reset    (reset),
        .s_in     (s_in),
        .s_valid  (s_valid),
        .resync   (resync),
`ifdef JESD204B_DESCR_BYPASS_EN
        .bypass   (bypass),
`endif
        .d_out    (d_out),
        .d_valid  (d_valid),
        .locked   (locked),
        .word_cnt (word_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Transmit scrambler model: S[i] = D[i] ^ S[i+14] ^ S[i+15], earliest bit first.
    task automatic scramble(input logic [31:0] d, output logic [31:0] s);
        logic [46:0] e;
        e = '0;
        e[46:32] = tx_hist;
        for (int i = 31; i >= 0; i--)
            e[i] = d[i] ^ e[i+14] ^ e[i+15];
        s = e[31:0];
        tx_hist = e[14:0];
    endtask

    // Drive one cycle of inputs, sample outputs 1 time unit after the edge.
    task automatic cyc(input logic rs, input logic sv, input logic [31:0] si);
        resync  = rs;
        s_valid = sv;
        s_in    = si;
        @(posedge clk);
        #1;
        resync  = 1'b0;
        s_valid = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_dout"},  d_out, 32'h0);
        check({tag, "_dvld"},  {31'b0, d_valid}, 32'h0);
        check({tag, "_lock"},  {31'b0, locked}, 32'h1);
        check({tag, "_cnt"},   {16'b0, word_cnt}, 32'h0);
    endtask

    task automatic do_reset();
        #2 reset = 1'b1;
        #1 check_reset_vals("rst_mid");
        #2 reset = 1'b0;
        tx_hist = 15'h7F80;
    endtask

    initial begin
        logic [31:0] s, w;
        logic [15:0] cnt;

        reset = 1'b1; s_in = '0; s_valid = 1'b0; resync = 1'b0;
`ifdef JESD204B_DESCR_BYPASS_EN
        bypass = 1'b0;
`endif
        tx_hist = 15'h7F80;

        tbl[0]  = '{1'b1, 1'b1, 32'h00000000, 1'b0, 32'h0,        1'b0, 1'b1, 16'd0};
        tbl[1]  = '{1'b0, 1'b1, 32'h00000001, 1'b1, 32'h00000001, 1'b1, 1'b1, 16'd1};
        tbl[2]  = '{1'b0, 1'b1, 32'h00000000, 1'b1, 32'h00060000, 1'b1, 1'b1, 16'd2};
        tbl[3]  = '{1'b0, 1'b1, 32'h00000000, 1'b1, 32'h00000000, 1'b1, 1'b1, 16'd3};
        tbl[4]  = '{1'b0, 1'b0, 32'hFFFFFFFF, 1'b1, 32'h00000000, 1'b0, 1'b1, 16'd3};
        tbl[5]  = '{1'b1, 1'b0, 32'h00000000, 1'b1, 32'h00000000, 1'b0, 1'b0, 16'd3};
        tbl[6]  = '{1'b1, 1'b0, 32'h00000000, 1'b1, 32'h00000000, 1'b0, 1'b0, 16'd3};
        tbl[7]  = '{1'b0, 1'b0, 32'h00000000, 1'b1, 32'h00000000, 1'b0, 1'b0, 16'd3};
        tbl[8]  = '{1'b0, 1'b1, 32'h12345678, 1'b1, 32'h00000000, 1'b0, 1'b1, 16'd0};
        tbl[9]  = '{1'b0, 1'b1, 32'h00000000, 1'b1, 32'hF5100000, 1'b1, 1'b1, 16'd1};
        tbl[10] = '{1'b0, 1'b1, 32'h00000000, 1'b1, 32'h00000000, 1'b1, 1'b1, 16'd2};
        tbl[11] = '{1'b1, 1'b1, 32'hAAAAAAAA, 1'b1, 32'h00000000, 1'b0, 1'b1, 16'd0};
        tbl[12] = '{1'b0, 1'b1, 32'h00000000, 1'b1, 32'hFFFC0000, 1'b1, 1'b1, 16'd1};

        dat[0] = 32'hDEADBEEF;
        dat[1] = 32'h00000000;
        dat[2] = 32'hFFFFFFFF;
        for (int k = 3; k < 1003; k++) dat[k] = $urandom;

        #3 check_reset_vals("rst");
        #9 reset = 1'b0;

        // Loopback from joint reset
        for (int k = 0; k < 1003; k++) begin
            scramble(dat[k], s);
            cyc(1'b0, 1'b1, s);
            check("loop_dout", d_out, dat[k]);
            check("loop_dvld", {31'b0, d_valid}, 32'h1);
        end
        check("loop_cnt",  {16'b0, word_cnt}, 32'd1003);
        check("loop_lock", {31'b0, locked}, 32'h1);

        // Mid-stream reset, then gapped loopback
        do_reset();
        cnt = 16'd0;
        for (int k = 0; k < 300; k++) begin
            if ($urandom_range(0, 99) < 30) begin
                cyc(1'b0, 1'b0, $urandom);
                check("gap_dvld", {31'b0, d_valid}, 32'h0);
            end else begin
                scramble(dat[k], s);
                cyc(1'b0, 1'b1, s);
                cnt++;
                check("gap_dout", d_out, dat[k]);
                check("gap_dvld", {31'b0, d_valid}, 32'h1);
            end
            check("gap_cnt", {16'b0, word_cnt}, {16'b0, cnt});
        end

        // Impulse / resync table
        for (int v = 0; v < 13; v++) begin
            cyc(tbl[v].rs, tbl[v].sv, tbl[v].si);
            if (tbl[v].chk_d) check($sformatf("tbl%0d_dout", v), d_out, tbl[v].ed);
            check($sformatf("tbl%0d_dvld", v), {31'b0, d_valid}, {31'b0, tbl[v].edv});
            check($sformatf("tbl%0d_lock", v), {31'b0, locked},  {31'b0, tbl[v].elk});
            check($sformatf("tbl%0d_cnt", v),  {16'b0, word_cnt}, {16'b0, tbl[v].ecnt});
        end

        // Corruption of one scrambled word (bit 5 of word 10)
        do_reset();
        for (int k = 0; k < 20; k++) begin
            scramble(dat[k], s);
            if (k == 10) s = s ^ 32'h00000020;
            cyc(1'b0, 1'b1, s);
            if (k == 10)      w = dat[k] ^ 32'h00000020;
            else if (k == 11) w = dat[k] ^ 32'h00C00000;
            else              w = dat[k];
            check($sformatf("corr%0d_dout", k), d_out, w);
            check("corr_lock", {31'b0, locked}, 32'h1);
        end

        // Saturation
        do_reset();
        for (int k = 0; k < 65534; k++) cyc(1'b0, 1'b1, 32'h0);
        check("sat_fffe", {16'b0, word_cnt}, 32'h0000FFFE);
        cyc(1'b0, 1'b1, 32'h0);
        check("sat_ffff", {16'b0, word_cnt}, 32'h0000FFFF);
        for (int k = 0; k < 5; k++) cyc(1'b0, 1'b1, 32'h0);
        check("sat_hold", {16'b0, word_cnt}, 32'h0000FFFF);
        check("sat_dvld", {31'b0, d_valid}, 32'h1);

`ifdef JESD204B_DESCR_BYPASS_EN
        bypass = 1'b1;
        cyc(1'b0, 1'b1, 32'h13572468);
        check("byp_dout", d_out, 32'h13572468);
        check("byp_dvld", {31'b0, d_valid}, 32'h1);
        cyc(1'b0, 1'b1, 32'hCAFEF00D);
        check("byp_dout2", d_out, 32'hCAFEF00D);
        bypass = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
